// File: rtl/alu_issue_sequencer.sv
// Issue sequencer for an external combinational 8-bit ALU: accepts one instruction at a time,
// supplies its operands from a 4x8 register file, and retires the result into the file and PC.
module alu_issue_sequencer #(
   parameter int OFFSET_W = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [15:0] instr,
   input  logic        load_en,
   input  logic [1:0]  load_addr,
   input  logic [7:0]  load_data,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [2:0]  alu_sel,
   input  logic [7:0]  alu_f,
   input  logic        alu_ovf,
   input  logic        alu_take_branch,
   output logic        retire_valid,
   output logic [7:0]  retire_data,
   output logic        retire_ovf,
   output logic        branch_taken,
   output logic [7:0]  pc,
   output logic        ovf_sticky
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXEC   = 2'd1;
   localparam logic [1:0] S_RETIRE = 2'd2;

   logic [1:0]                 state;
   logic [7:0]                 rf [4];
   logic [1:0]                 rd_q;
   logic signed [OFFSET_W-1:0] off_q;
   logic                       branch_q;
   logic                       accept;
   logic                       is_branch;
   logic                       writeback;
   logic signed [7:0]          off_ext;

   assign instr_ready  = (state == S_IDLE) && !reset;
   assign accept       = instr_valid && instr_ready;
   assign retire_valid = (state == S_RETIRE);
   assign branch_taken = branch_q && retire_valid;
   // alu_sel holds the latched opcode for the whole instruction, so it doubles as the op register.
   assign is_branch    = (alu_sel[2:1] == 2'b11);
   assign writeback    = (state == S_EXEC) && !is_branch;
   assign off_ext      = 8'(off_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (accept) state <= S_EXEC;
            S_EXEC:  state <= S_RETIRE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // NOTE: non-blocking writes mean the accept-edge operand read sees the pre-load value, and
   // the later writeback assignment overrides a load to the same index on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the register file is architecturally visible state, so it is reset like a flop bank.
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else begin
         if (load_en)   rf[load_addr] <= load_data;
         if (writeback) rf[rd_q]      <= alu_f;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_a       <= 8'h00;
         alu_b       <= 8'h00;
         alu_sel     <= 3'b000;
         rd_q        <= 2'b00;
         off_q       <= '0;
         retire_data <= 8'h00;
         retire_ovf  <= 1'b0;
         branch_q    <= 1'b0;
         pc          <= 8'h00;
         ovf_sticky  <= 1'b0;
      end else begin
         if (accept) begin
            alu_a   <= rf[instr[10:9]];
            alu_b   <= rf[instr[8:7]];
            alu_sel <= instr[15:13];
            rd_q    <= instr[12:11];
            off_q   <= instr[OFFSET_W-1:0];
         end
         if (state == S_EXEC) begin
            retire_data <= alu_f;
            retire_ovf  <= alu_ovf;
            branch_q    <= alu_take_branch && is_branch;
            ovf_sticky  <= ovf_sticky | alu_ovf;
            if (alu_take_branch && is_branch) pc <= pc + off_ext;
            else                              pc <= pc + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed bench for alu_issue_sequencer with a behavioural ALU model and hand-computed results.
module tb_alu_issue_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic        load_en;
   logic [1:0]  load_addr;
   logic [7:0]  load_data;
   logic [7:0]  alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic [7:0]  alu_f;
   logic        alu_ovf;
   logic        alu_take_branch;
   logic        retire_valid;
   logic [7:0]  retire_data;
   logic        retire_ovf;
   logic        branch_taken;
   logic [7:0]  pc;
   logic        ovf_sticky;

   logic        force_tb = 1'b0;
   logic        model_tb;
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [7:0]  exp_pc   = 8'h00;

   // values observed by issue()
   logic [7:0]  ex_a, ex_b, rt_data, rt_pc;
   logic [2:0]  ex_sel;
   logic        ex_ready, rt_valid, rt_ovf, rt_bt, rt_sticky, post_ready, post_rv;

   logic [8:0]  ready_mask, rv_mask;

   alu_issue_sequencer #(.OFFSET_W(7)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_f(alu_f), .alu_ovf(alu_ovf), .alu_take_branch(alu_take_branch),
      .retire_valid(retire_valid), .retire_data(retire_data), .retire_ovf(retire_ovf),
      .branch_taken(branch_taken), .pc(pc), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_f    = 8'h00;
      alu_ovf  = 1'b0;
      model_tb = 1'b0;
      case (alu_sel)
         3'b000: begin
            alu_f   = alu_a + alu_b;
            alu_ovf = (alu_a[7] == alu_b[7]) && (alu_f[7] != alu_a[7]);
         end
         3'b001:  alu_f = ~alu_b;
         3'b010:  alu_f = alu_a & alu_b;
         3'b011:  alu_f = alu_a | alu_b;
         3'b100:  alu_f = alu_a >> 1;
         3'b101:  alu_f = alu_a << 1;
         3'b110:  model_tb = (alu_a == alu_b);
         default: model_tb = (alu_a != alu_b);
      endcase
      alu_take_branch = model_tb | force_tb;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb,
                                      input logic [6:0] off);
      return {op, rd, ra, rb, off};
   endfunction

   task automatic load(input logic [1:0] addr, input logic [7:0] data);
      load_en = 1'b1; load_addr = addr; load_data = data;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   // Called at a negedge while idle; returns at the negedge after retirement.
   task automatic issue(input logic [15:0] ins, input bit ld_acc = 0, input bit ld_wb = 0,
                        input logic [1:0] ld_addr = 2'd0, input logic [7:0] ld_data = 8'h00);
      int waited = 0;
      instr = ins; instr_valid = 1'b1;
      load_en = ld_acc; load_addr = ld_addr; load_data = ld_data;
      while (!instr_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!instr_ready) check("ready_timeout", 32'(instr_ready), 32'd1);
      @(negedge clk);
      ex_a = alu_a; ex_b = alu_b; ex_sel = alu_sel; ex_ready = instr_ready;
      instr_valid = 1'b0; load_en = ld_wb;
      @(negedge clk);
      rt_valid = retire_valid; rt_data = retire_data; rt_ovf = retire_ovf;
      rt_bt = branch_taken; rt_pc = pc; rt_sticky = ovf_sticky;
      load_en = 1'b0;
      @(negedge clk);
      post_ready = instr_ready; post_rv = retire_valid;
   endtask

   task automatic check_retire(input string tag, input logic [7:0] data, input logic ovf,
                               input logic bt);
      check({tag, "_rv"},    32'(rt_valid), 32'd1);
      check({tag, "_data"},  32'(rt_data),  32'(data));
      check({tag, "_ovf"},   32'(rt_ovf),   32'(ovf));
      check({tag, "_bt"},    32'(rt_bt),    32'(bt));
      check({tag, "_pc"},    32'(rt_pc),    32'(exp_pc));
      check({tag, "_busy"},  32'({ex_ready, post_rv, post_ready}), 32'b001);
   endtask

   task automatic read_reg(input logic [1:0] idx, input logic [7:0] exp);
      issue(mk(3'b011, idx, idx, idx, 7'h00));
      exp_pc = exp_pc + 8'd1;
      check($sformatf("r%0d_val", idx), 32'(ex_a), 32'(exp));
      check($sformatf("r%0d_pc", idx), 32'(rt_pc), 32'(exp_pc));
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
      load_en = 1'b0; load_addr = 2'd0; load_data = 8'h00;
      @(negedge clk);
      check("rst_ready", 32'(instr_ready), 32'd0);
      check("rst_outs", {alu_a, alu_b, 5'(alu_sel), pc},
            32'h0);
      check("rst_retire", {retire_data, 4'(retire_valid), 4'(retire_ovf), 4'(branch_taken),
            4'(ovf_sticky), 8'h00}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1 check("rel_ready", 32'(instr_ready), 32'd1);

      // add with signed overflow
      load(2'd1, 8'h70);
      load(2'd2, 8'h20);
      issue(mk(3'b000, 2'd3, 2'd1, 2'd2, 7'h00));
      exp_pc = 8'h01;
      check("add_ops", {13'h0, ex_a, ex_b, ex_sel}, {13'h0, 8'h70, 8'h20, 3'b000});
      check_retire("add", 8'h90, 1'b1, 1'b0);
      check("add_sticky", 32'(rt_sticky), 32'd1);
      read_reg(2'd3, 8'h90);

      // beq taken, offset -4 from pc 0x02
      load(2'd1, 8'h55);
      load(2'd2, 8'h55);
      issue(mk(3'b110, 2'd3, 2'd1, 2'd2, 7'h7C));
      exp_pc = 8'hFE;
      check("beq_sel", 32'(ex_sel), 32'd6);
      check_retire("beq", 8'h00, 1'b0, 1'b1);
      read_reg(2'd3, 8'h90);

      // bne not taken, pc wraps 0xFF -> 0x00
      issue(mk(3'b111, 2'd3, 2'd1, 2'd2, 7'h05));
      exp_pc = 8'h00;
      check_retire("bne", 8'h00, 1'b0, 1'b0);

      // or with a spurious branch flag from the ALU
      force_tb = 1'b1;
      issue(mk(3'b011, 2'd0, 2'd1, 2'd3, 7'h10));
      force_tb = 1'b0;
      exp_pc = 8'h01;
      check_retire("or_spur", 8'hD5, 1'b0, 1'b0);
      read_reg(2'd0, 8'hD5);

      // load to r3 on the writeback edge of an add into r3: writeback wins
      issue(mk(3'b000, 2'd3, 2'd1, 2'd1, 7'h00), 0, 1, 2'd3, 8'h11);
      exp_pc = 8'h03;
      check_retire("coll_wb", 8'hAA, 1'b1, 1'b0);
      read_reg(2'd3, 8'hAA);

      // load to r2 on the accept edge: operand sees the old value
      issue(mk(3'b011, 2'd0, 2'd2, 2'd2, 7'h00), 1, 0, 2'd2, 8'h33);
      exp_pc = 8'h05;
      check("coll_acc_a", 32'(ex_a), 32'h55);
      check_retire("coll_acc", 8'h55, 1'b0, 1'b0);
      read_reg(2'd2, 8'h33);

      // shl still drives alu_b from rs_b
      issue(mk(3'b101, 2'd1, 2'd2, 2'd3, 7'h00));
      exp_pc = 8'h07;
      check("shl_ops", {13'h0, ex_a, ex_b, ex_sel}, {13'h0, 8'h33, 8'hAA, 3'b101});
      check_retire("shl", 8'h66, 1'b0, 1'b0);

      // instr_valid held continuously: accepts every 3 cycles
      instr = mk(3'b011, 2'd0, 2'd0, 2'd0, 7'h00);
      instr_valid = 1'b1;
      ready_mask = '0; rv_mask = '0;
      ready_mask[0] = instr_ready; rv_mask[0] = retire_valid;
      for (int k = 1; k < 9; k++) begin
         @(negedge clk);
         ready_mask[k] = instr_ready; rv_mask[k] = retire_valid;
      end
      instr_valid = 1'b0;
      @(negedge clk);
      check("held_ready", 32'(ready_mask), 32'b001001001);
      check("held_rv",    32'(rv_mask),    32'b100100100);
      check("held_pc",    32'(pc),         32'h0A);

      // reset asserted in EXEC
      instr = mk(3'b000, 2'd0, 2'd1, 2'd2, 7'h00);
      instr_valid = 1'b1;
      @(negedge clk);
      check("pre_rst_a", 32'(alu_a), 32'h66);
      instr_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("mid_rst_outs", {alu_a, alu_b, 5'(alu_sel), pc}, 32'h0);
      check("mid_rst_ret", {retire_data, 4'(retire_valid), 4'(retire_ovf), 4'(branch_taken),
            4'(ovf_sticky), 4'(instr_ready), 4'h0}, 32'h0);
      @(negedge clk);
      check("mid_rst_norv", 32'(retire_valid), 32'd0);
      reset = 1'b0;
      #1 check("mid_rst_rel", 32'(instr_ready), 32'd1);
      exp_pc = 8'h00;
      issue(mk(3'b000, 2'd0, 2'd1, 2'd2, 7'h00));
      exp_pc = 8'h01;
      check("post_rst_r12", {16'h0, ex_a, ex_b}, 32'h0);
      check_retire("post_rst", 8'h00, 1'b0, 1'b0);
      check("post_rst_sticky", 32'(rt_sticky), 32'd0);
      issue(mk(3'b011, 2'd1, 2'd3, 2'd0, 7'h00));
      exp_pc = 8'h02;
      check("post_rst_r30", {16'h0, ex_a, ex_b}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
